mac_unit_wave_acc: RTL and testbench
====================================

# mac_unit_wave_acc

Parametrised bit-serial weight MAC for the Wave array. It consumes one weight bit-column per accepted beat across VEC_LENGTH activation lanes, shifts the column partial sum by its bit position, and accumulates it internally with saturation. After the last column it presents the dot product through a valid/ready handshake. It sits between the activation/weight-bit feeder and the output buffer, and replaces the fixed 16-lane, non-accumulating MAC.

## Interface
- DATA_WIDTH, 8: activation width, signed.
- VEC_LENGTH, 16: lane count; a power of 2, ≥ 2.
- W_BITS, 8: weight bit-columns per dot product; range 2..8.
- IDX_WIDTH, $clog2(W_BITS): width of column_idx.
- PSUM_WIDTH, DATA_WIDTH+1+$clog2(VEC_LENGTH)+W_BITS-1: width of a shifted column sum.
- ACC_WIDTH, DATA_WIDTH+16: accumulator and result width; must be ≥ PSUM_WIDTH (elaboration error otherwise).
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- en  in  1  global enable; when 0, all registers hold.
- start  in  1  begins a job; honoured only in IDLE with en=1.
- load_accum  in  1  sampled with start; 1 seeds the accumulator with accum_prev, 0 seeds it with 0.
- accum_prev  in  ACC_WIDTH  signed seed value.
- col_valid  in  1  column beat valid.
- col_ready  out  1  en && state==ACCUM.
- act_in  in  DATA_WIDTH × VEC_LENGTH  signed activations.
- sign  in  1 × VEC_LENGTH  per-lane negate.
- w_bit  in  1 × VEC_LENGTH  per-lane weight bit.
- column_idx  in  IDX_WIDTH  bit position of this column.
- col_last  in  1  marks the final column of the job.
- result  out  ACC_WIDTH  accumulator value.
- result_valid  out  1  result is final; state==DONE.
- result_ready  in  1  consumer accepts the result.
- overflow  out  1  sticky saturation flag for the current job.
- busy  out  1  state != IDLE.

## Operation
- Lane term: sign=1 gives −act (computed at DATA_WIDTH+1 bits, so −(−2^(DATA_WIDTH−1)) is exact); w_bit=0 gives 0.
- Lane terms are summed by a balanced adder tree; the sum is DATA_WIDTH+1+log2(VEC_LENGTH) bits, sign-extended.
- The sum is shifted left by column_idx. If column_idx ≥ W_BITS (non-power-of-2 W_BITS), the column contributes 0.
- Accumulation: acc + sign-extended shifted sum. On overflow, acc saturates to the signed ACC_WIDTH max/min and overflow sets. overflow clears only on an accepted start or on reset.
- FSM:
  - IDLE → ACCUM on start.
  - ACCUM → DRAIN on accepting a beat with col_last=1.
  - DRAIN → DONE unconditionally.
  - DONE → IDLE on result_ready.
  - All transitions require en=1.
- start is ignored outside IDLE. Beats are never accepted in IDLE, DRAIN or DONE.
- Reset values: state IDLE; acc/result 0; overflow, result_valid, busy, col_ready 0; pipeline valid bit 0.

## Timing
- Beat accepted at edge k (col_valid && col_ready && en).
- Shifted sum registered in stage S1 at edge k.
- acc updated from S1 at edge k+1.
- For a col_last beat, result_valid is high from edge k+1 and result holds the final sum.
- Back-to-back beats are supported, one per cycle. Gaps in col_valid are allowed.
- en=0 freezes FSM, S1, acc and outputs. col_ready is 0 and result_ready is ignored. Resuming is lossless.
- result and result_valid hold until a handshake with result_ready=1.
- start accepted at edge s: acc is seeded at edge s and col_ready is high from edge s.
- Reset has priority over all events. Reset mid-job aborts it, with outputs at reset values next cycle.

## Structure
- Package mac_wave_pkg:
  - state enum {IDLE, ACCUM, DRAIN, DONE};
  - width helper function for PSUM_WIDTH;
  - saturating-add function.
- Sub-module mac_wave_lane_tree: combinational sign-select, value-select and generated adder tree, parametrised on DATA_WIDTH and VEC_LENGTH.
- Top level: S1 register, accumulator, FSM and handshake.

## Test plan
All cases use the defaults (16 lanes, 8-bit, W_BITS=8, ACC_WIDTH=24).
1. All act=1, sign=0, w_bit=1; columns idx 0..7 back-to-back, last on idx 7; load_accum=0 → result=4080, result_valid one cycle after the DRAIN edge, overflow=0.
2. All act=−128, sign=1, w_bit=1; a single column idx 7 with last; load_accum=1, accum_prev=−100 → result=262044.
3. Lane 0 act=5 (others w_bit=0), weight −3 (bits 0,2,3,4,5,6 with sign=0, bit 7 with sign=1), 8 beats → result=−15.
4. load_accum=1, accum_prev=8388607, column all act=1 idx 0 last → result=8388607, overflow=1; the next start with load_accum=0 clears overflow.
5. Repeat case 1 with col_valid gaps and en=0 for 3 cycles mid-job, result_ready low 5 cycles, start pulsed during DONE → result still 4080, held stable, start ignored, busy=1 until the handshake.
6. reset asserted during ACCUM after 3 beats → next cycle result=0, result_valid=0, col_ready=0, busy=0; a fresh case 1 job then yields 4080.

Source files
------------

// File: rtl/mac_wave_pkg.sv
// Shared types and helpers for the Wave bit-serial MAC.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package mac_wave_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Width of a column sum after the largest bit-position shift.
  function automatic int psum_width(input int dw, input int vl, input int wb);
    return dw + 1 + $clog2(vl) + wb - 1;
  endfunction

  // Signed add clamped to a 'width'-bit signed range; bit 64 flags a clamp.
  // Operands arrive sign-extended to 64 bits, so the raw sum cannot wrap.
  function automatic logic [64:0] sat_add(input logic signed [63:0] a,
                                          input logic signed [63:0] b,
                                          input int width);
    logic signed [63:0] sum;
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    sum   = a + b;
    max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
    min_v = -max_v - 64'sd1;
    if (sum > max_v) begin
      sat_add = {1'b1, max_v};
    end else if (sum < min_v) begin
      sat_add = {1'b1, min_v};
    end else begin
      sat_add = {1'b0, sum};
    end
  endfunction

endpackage

// File: rtl/mac_wave_lane_tree.sv
// Per-lane sign/weight-bit select followed by a balanced adder tree.
// Latency: combinational.
// Backpressure: none; the parent decides when the sum is captured.
module mac_wave_lane_tree #(
  parameter int DATA_WIDTH = 8,
  parameter int VEC_LENGTH = 16,
  localparam int TW = DATA_WIDTH + 1,
  localparam int SW = TW + $clog2(VEC_LENGTH)
) (
  input  logic [DATA_WIDTH*VEC_LENGTH-1:0] act_in,
  input  logic [VEC_LENGTH-1:0]            sign,
  input  logic [VEC_LENGTH-1:0]            w_bit,
  output logic [SW-1:0]                    col_sum
);

  localparam int LEVELS = $clog2(VEC_LENGTH);

  logic signed [TW-1:0] terms [VEC_LENGTH];

  // One extra bit of headroom keeps the negation of the most negative activation exact.
  for (genvar i = 0; i < VEC_LENGTH; i++) begin : g_lane
    logic signed [TW-1:0] a_ext;
    assign a_ext    = TW'($signed(act_in[i*DATA_WIDTH +: DATA_WIDTH]));
    assign terms[i] = !w_bit[i] ? '0 : (sign[i] ? -a_ext : a_ext);
  end

  // Level 0 holds the sign-extended lane terms; each higher level halves the count.
  for (genvar lv = 0; lv <= LEVELS; lv++) begin : g_lvl
    localparam int N = VEC_LENGTH >> lv;
    logic signed [SW-1:0] s [N];
    for (genvar j = 0; j < N; j++) begin : g_n
      if (lv == 0) begin : g_leaf
        assign s[j] = SW'(terms[j]);
      end else begin : g_add
        assign s[j] = g_lvl[lv-1].s[2*j] + g_lvl[lv-1].s[2*j+1];
      end
    end
  end

  assign col_sum = g_lvl[LEVELS].s[0];

endmodule

// File: rtl/mac_unit_wave_acc.sv
// Bit-serial weight MAC: shifts each weight bit-column sum into a saturating accumulator.
// Latency: beat accepted at edge k is registered at k, accumulated at k+1; result_valid from k+1 after col_last.
// Backpressure: col_ready only in ACCUM with en=1; result held until result_ready while en=1.
module mac_unit_wave_acc
  import mac_wave_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int VEC_LENGTH = 16,
  parameter int W_BITS     = 8,
  parameter int IDX_WIDTH  = $clog2(W_BITS),
  parameter int PSUM_WIDTH = psum_width(DATA_WIDTH, VEC_LENGTH, W_BITS),
  parameter int ACC_WIDTH  = DATA_WIDTH + 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            en,
  input  logic                            start,
  input  logic                            load_accum,
  input  logic [ACC_WIDTH-1:0]            accum_prev,
  input  logic                            col_valid,
  output logic                            col_ready,
  input  logic [DATA_WIDTH*VEC_LENGTH-1:0] act_in,
  input  logic [VEC_LENGTH-1:0]           sign,
  input  logic [VEC_LENGTH-1:0]           w_bit,
  input  logic [IDX_WIDTH-1:0]            column_idx,
  input  logic                            col_last,
  output logic [ACC_WIDTH-1:0]            result,
  output logic                            result_valid,
  input  logic                            result_ready,
  output logic                            overflow,
  output logic                            busy
);

  localparam int SW = DATA_WIDTH + 1 + $clog2(VEC_LENGTH);

  if (ACC_WIDTH < PSUM_WIDTH || ACC_WIDTH > 62) begin : g_bad_width
    $error("mac_unit_wave_acc: ACC_WIDTH must be >= PSUM_WIDTH and <= 62");
  end

  state_t                        state;
  logic                          s1_vld;
  logic signed [PSUM_WIDTH-1:0]  s1_psum;
  logic signed [ACC_WIDTH-1:0]   acc;

  logic [SW-1:0]                 col_sum;
  logic signed [PSUM_WIDTH-1:0]  sum_ext;
  logic signed [PSUM_WIDTH-1:0]  col_psum;
  logic                          beat_acc;
  logic                          start_acc;
  logic                          sat_ovf;
  logic signed [63:0]            sat_sum;
  logic                          unused_sat_hi;

  mac_wave_lane_tree #(
    .DATA_WIDTH (DATA_WIDTH),
    .VEC_LENGTH (VEC_LENGTH)
  ) u_tree (
    .act_in  (act_in),
    .sign    (sign),
    .w_bit   (w_bit),
    .col_sum (col_sum)
  );

  assign col_ready    = en && (state == ACCUM);
  assign beat_acc     = col_ready && col_valid;
  assign start_acc    = en && (state == IDLE) && start;
  assign result       = acc;
  assign result_valid = (state == DONE);
  assign busy         = (state != IDLE);

  // Weight the column by its bit position; positions past W_BITS carry no weight.
  always_comb begin
    sum_ext  = {{(PSUM_WIDTH-SW){col_sum[SW-1]}}, col_sum};
    col_psum = '0;
    if (32'(column_idx) < W_BITS) begin
      col_psum = sum_ext <<< column_idx;
    end
  end

  // Clamp the running sum to the accumulator range.
  always_comb begin
    {sat_ovf, sat_sum} = sat_add(64'(acc), 64'(s1_psum), ACC_WIDTH);
  end
  assign unused_sat_hi = ^sat_sum[63:ACC_WIDTH];

  // Job sequencing: wait for start, take columns until col_last, settle, hand off the result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else if (en) begin
      case (state)
        IDLE:    if (start) state <= ACCUM;
        ACCUM:   if (col_valid && col_last) state <= DRAIN;
        DRAIN:   state <= DONE;
        DONE:    if (result_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Stage S1 captures the shifted column sum of each accepted beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_vld  <= 1'b0;
      s1_psum <= '0;
    end else if (en) begin
      s1_vld <= beat_acc;
      if (beat_acc) begin
        s1_psum <= col_psum;
      end
    end
  end

  // Accumulator seeds on start and folds in S1; overflow is sticky for the job.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc      <= '0;
      overflow <= 1'b0;
    end else if (en) begin
      if (start_acc) begin
        acc      <= load_accum ? $signed(accum_prev) : '0;
        overflow <= 1'b0;
      end else if (s1_vld) begin
        acc <= sat_sum[ACC_WIDTH-1:0];
        if (sat_ovf) begin
          overflow <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mac_unit_wave_acc.sv
// Directed bench for mac_unit_wave_acc at default parameters.
// Latency: checks sample 1 time unit after each rising edge.
// Backpressure: exercises col_valid gaps, en stalls and held results.
module tb_mac_unit_wave_acc;

  localparam int DW = 8;
  localparam int VL = 16;
  localparam int WB = 8;
  localparam int IW = 3;
  localparam int AW = 24;

  logic              clk;
  logic              reset;
  logic              en;
  logic              start;
  logic              load_accum;
  logic [AW-1:0]     accum_prev;
  logic              col_valid;
  logic              col_ready;
  logic [DW*VL-1:0]  act_in;
  logic [VL-1:0]     sign;
  logic [VL-1:0]     w_bit;
  logic [IW-1:0]     column_idx;
  logic              col_last;
  logic [AW-1:0]     result;
  logic              result_valid;
  logic              result_ready;
  logic              overflow;
  logic              busy;

  int passes = 0;
  int total  = 0;

  mac_unit_wave_acc #(
    .DATA_WIDTH (DW),
    .VEC_LENGTH (VL),
    .W_BITS     (WB),
    .IDX_WIDTH  (IW),
    .ACC_WIDTH  (AW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .en           (en),
    .start        (start),
    .load_accum   (load_accum),
    .accum_prev   (accum_prev),
    .col_valid    (col_valid),
    .col_ready    (col_ready),
    .act_in       (act_in),
    .sign         (sign),
    .w_bit        (w_bit),
    .column_idx   (column_idx),
    .col_last     (col_last),
    .result       (result),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .overflow     (overflow),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout observed no finish required finish by 200000");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input longint obs, input longint exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic set_all(input logic [DW-1:0] a, input logic s, input logic w);
    for (int i = 0; i < VL; i++) act_in[i*DW +: DW] = a;
    sign  = {VL{s}};
    w_bit = {VL{w}};
  endtask

  task automatic start_job(input logic load, input logic [AW-1:0] prev);
    start      = 1'b1;
    load_accum = load;
    accum_prev = prev;
    tick();
    start      = 1'b0;
    load_accum = 1'b0;
  endtask

  task automatic beat(input int idx, input logic last);
    col_valid  = 1'b1;
    column_idx = IW'(idx);
    col_last   = last;
    tick();
    col_valid  = 1'b0;
    col_last   = 1'b0;
  endtask

  task automatic finish_job(input string tag, input longint exp, input logic exp_ovf);
    int n = 0;
    while (!result_valid && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_valid"}, longint'(result_valid), 1);
    chk({tag, "_result"}, longint'($signed(result)), exp);
    chk({tag, "_ovf"}, longint'(overflow), longint'(exp_ovf));
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    chk({tag, "_idle"}, longint'(busy), 0);
  endtask

  task automatic case1_job(input string tag);
    set_all(8'd1, 1'b0, 1'b1);
    start_job(1'b0, '0);
    for (int i = 0; i < 8; i++) beat(i, i == 7);
    finish_job(tag, 4080, 1'b0);
  endtask

  logic [7:0] wpat;

  initial begin
    reset = 1'b1; en = 1'b0; start = 1'b0; load_accum = 1'b0; accum_prev = '0;
    col_valid = 1'b0; act_in = '0; sign = '0; w_bit = '0; column_idx = '0;
    col_last = 1'b0; result_ready = 1'b0;
    tick(); tick();
    en = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_result", longint'(result), 0);
    chk("rst_valid", longint'(result_valid), 0);
    chk("rst_col_ready", longint'(col_ready), 0);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_ovf", longint'(overflow), 0);

    // Case 1: eight back-to-back columns of sixteen ones.
    set_all(8'd1, 1'b0, 1'b1);
    start_job(1'b0, '0);
    chk("c1_col_ready", longint'(col_ready), 1);
    chk("c1_busy", longint'(busy), 1);
    for (int i = 0; i < 8; i++) beat(i, i == 7);
    chk("c1_drain_valid", longint'(result_valid), 0);
    chk("c1_drain_col_ready", longint'(col_ready), 0);
    tick();
    chk("c1_done_valid", longint'(result_valid), 1);
    finish_job("c1", 4080, 1'b0);

    // Case 2: negated -128 on all lanes at bit 7, seeded with -100.
    set_all(8'h80, 1'b1, 1'b1);
    start_job(1'b1, AW'(-100));
    beat(7, 1'b1);
    finish_job("c2", 262044, 1'b0);

    // Case 3: single lane, activation 5 times weight -3.
    set_all(8'd5, 1'b0, 1'b0);
    wpat = 8'hFD;
    start_job(1'b0, '0);
    for (int i = 0; i < 8; i++) begin
      w_bit = {{(VL-1){1'b0}}, wpat[i]};
      sign  = {{(VL-1){1'b0}}, i == 7};
      beat(i, i == 7);
    end
    finish_job("c3", -15, 1'b0);

    // Case 4: saturate at the positive limit, then a fresh start clears overflow.
    set_all(8'd1, 1'b0, 1'b1);
    start_job(1'b1, AW'(8388607));
    beat(0, 1'b1);
    finish_job("c4_sat", 8388607, 1'b1);
    start_job(1'b0, '0);
    chk("c4_ovf_cleared", longint'(overflow), 0);
    beat(0, 1'b1);
    finish_job("c4_next", 16, 1'b0);

    // Case 5: gaps, an en stall with col_valid asserted, held result, stray start.
    set_all(8'd1, 1'b0, 1'b1);
    start_job(1'b0, '0);
    beat(0, 1'b0);
    tick();
    beat(1, 1'b0);
    beat(2, 1'b0);
    en = 1'b0;
    col_valid = 1'b1; column_idx = 3'd3;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("c5_stall_col_ready", longint'(col_ready), 0);
    end
    col_valid = 1'b0;
    en = 1'b1;
    beat(3, 1'b0);
    tick(); tick();
    for (int i = 4; i < 8; i++) beat(i, i == 7);
    tick();
    for (int i = 0; i < 5; i++) begin
      start = (i == 2);
      tick();
      chk("c5_hold_valid", longint'(result_valid), 1);
      chk("c5_hold_result", longint'($signed(result)), 4080);
      chk("c5_hold_busy", longint'(busy), 1);
    end
    start = 1'b0;
    en = 1'b0;
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    en = 1'b1;
    chk("c5_en0_ready_ignored", longint'(result_valid), 1);
    finish_job("c5", 4080, 1'b0);
    tick();
    chk("c5_start_not_latched", longint'(busy), 0);

    // Case 6: reset in the middle of a job, then a clean job.
    set_all(8'd1, 1'b0, 1'b1);
    start_job(1'b0, '0);
    beat(0, 1'b0);
    beat(1, 1'b0);
    beat(2, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("c6_rst_result", longint'(result), 0);
    chk("c6_rst_valid", longint'(result_valid), 0);
    chk("c6_rst_col_ready", longint'(col_ready), 0);
    chk("c6_rst_busy", longint'(busy), 0);
    case1_job("c6_fresh");

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
